seg7_value_display: RTL and testbench

- Output stage downstream of the CPU's io2_out GPIO register.
- Takes the 32-bit value the program writes there and drives the eight active-low seven-segment displays HEX0..HEX7.
- Decimal mode uses a sequential double-dabble converter. Hex mode is a direct nibble display.
- Instantiated in top between the CPU and the HEX pins.

---
 rtl/seg7_pkg.sv | 38 +++
 rtl/seg7_encode.sv | 19 +
 rtl/seg7_value_display.sv | 158 +++++++++++++++
 tb/tb_seg7_value_display.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment value display.
package seg7_pkg;

    // Controller states: wait for a new value, run double-dabble, load the display.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Active-low segment patterns {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Digit-to-segment table for 0-9 and A-F.
    localparam logic [6:0] SEG_CODES [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more,
    // so that the following left shift carries correctly into the next digit.
    function automatic logic [39:0] bcd_adjust(input logic [39:0] bcd);
        logic [39:0] res;
        res = bcd;
        for (int i = 0; i < 10; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// One display digit: 4-bit digit plus blank request to active-low segments.
module seg7_encode
    import seg7_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    // Table lookup, overridden by the blank request.
    always_comb begin
        if (i_blank) begin
            o_seg = SEG_BLANK;
        end else begin
            o_seg = SEG_CODES[i_digit];
        end
    end

endmodule

// File: rtl/seg7_value_display.sv
// Drives eight active-low seven-segment displays from a 32-bit value, either as
// hexadecimal nibbles or as decimal digits produced by a sequential
// double-dabble converter. Display state only changes in COMMIT, so the pins
// stay stable while a conversion is running.
module seg7_value_display
    import seg7_pkg::*;
#(
    parameter int BLANK_LZ     = 1,
    parameter int SHIFT_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    input  logic        hex_mode,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX7,
    output logic        busy,
    output logic        overflow
);

    localparam logic [4:0] LAST_ITER = 5'(SHIFT_CYCLES - 1);

    state_t           r_state;
    logic             r_busy;
    logic             r_dirty;
    logic [31:0]      r_last_val;
    logic             r_last_hex;
    logic             r_hex;
    logic [31:0]      r_bin;
    logic [39:0]      r_bcd;
    logic [4:0]       r_cnt;
    logic [7:0][3:0]  r_digit;
    logic [7:0]       r_blank;
    logic             r_overflow;

    logic             w_start;
    logic [39:0]      w_bcd_adj;
    logic [7:0][3:0]  w_cand;
    logic [7:0]       w_blank;
    logic             w_ovf;
    logic [6:0]       w_seg [8];

    // A new conversion is needed whenever the input pair differs from the last one captured.
    always_comb begin
        w_start   = r_dirty || (value != r_last_val) || (hex_mode != r_last_hex);
        w_bcd_adj = bcd_adjust(r_bcd);
        w_ovf     = !r_hex && (r_bcd[39:32] != 8'd0);
    end

    // Candidate display digits: captured nibbles in hex mode, BCD digits otherwise.
    always_comb begin
        w_cand = '0;
        for (int i = 0; i < 8; i++) begin
            if (r_hex) begin
                w_cand[i] = r_bin[4*i +: 4];
            end else begin
                w_cand[i] = r_bcd[4*i +: 4];
            end
        end
    end

    // Leading-zero mask: every digit above the most significant nonzero one is blanked; HEX0 never is.
    always_comb begin : blank_mask
        logic v_seen;
        v_seen  = 1'b0;
        w_blank = 8'h00;
        for (int i = 7; i >= 1; i--) begin
            v_seen     = v_seen || (w_cand[i] != 4'd0);
            w_blank[i] = (BLANK_LZ != 0) && !v_seen;
        end
    end

    // Controller, double-dabble datapath and display registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_dirty    <= 1'b1;
            r_last_val <= 32'd0;
            r_last_hex <= 1'b0;
            r_hex      <= 1'b0;
            r_bin      <= 32'd0;
            r_bcd      <= 40'd0;
            r_cnt      <= 5'd0;
            r_digit    <= '0;
            r_blank    <= 8'hFF;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_bin      <= value;
                        r_hex      <= hex_mode;
                        r_last_val <= value;
                        r_last_hex <= hex_mode;
                        r_dirty    <= 1'b0;
                        r_bcd      <= 40'd0;
                        r_cnt      <= 5'd0;
                        r_busy     <= 1'b1;
                        r_state    <= hex_mode ? COMMIT : SHIFT;
                    end else begin
                        r_busy     <= 1'b0;
                    end
                end
                SHIFT: begin
                    {r_bcd, r_bin} <= {w_bcd_adj[38:0], r_bin, 1'b0};
                    if (r_cnt == LAST_ITER) begin
                        r_cnt   <= 5'd0;
                        r_state <= COMMIT;
                    end else begin
                        r_cnt   <= r_cnt + 5'd1;
                    end
                end
                COMMIT: begin
                    r_digit    <= w_cand;
                    r_blank    <= w_blank;
                    r_overflow <= w_ovf;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // One encoder per display, fed only from the committed digit registers.
    for (genvar g = 0; g < 8; g++) begin : g_enc
        seg7_encode u_enc (
            .i_digit (r_digit[g]),
            .i_blank (r_blank[g]),
            .o_seg   (w_seg[g])
        );
    end

    // Overflow replaces every display with a dash.
    always_comb begin
        if (r_overflow) begin
            HEX0 = SEG_DASH; HEX1 = SEG_DASH; HEX2 = SEG_DASH; HEX3 = SEG_DASH;
            HEX4 = SEG_DASH; HEX5 = SEG_DASH; HEX6 = SEG_DASH; HEX7 = SEG_DASH;
        end else begin
            HEX0 = w_seg[0]; HEX1 = w_seg[1]; HEX2 = w_seg[2]; HEX3 = w_seg[3];
            HEX4 = w_seg[4]; HEX5 = w_seg[5]; HEX6 = w_seg[6]; HEX7 = w_seg[7];
        end
    end

    assign busy     = r_busy;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_seg7_value_display.sv
// Self-checking bench: two instances (blanking on and off) compared every cycle
// against a behavioural model that derives digits with plain division.
module tb_seg7_value_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] value = 32'd0;
    logic        hex_mode = 1'b0;

    logic [6:0]  a_hex [8];
    logic [6:0]  z_hex [8];
    logic        a_busy, z_busy, a_ovf, z_ovf;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    seg7_value_display #(.BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .value(value), .hex_mode(hex_mode),
        .HEX0(a_hex[0]), .HEX1(a_hex[1]), .HEX2(a_hex[2]), .HEX3(a_hex[3]),
        .HEX4(a_hex[4]), .HEX5(a_hex[5]), .HEX6(a_hex[6]), .HEX7(a_hex[7]),
        .busy(a_busy), .overflow(a_ovf)
    );

    seg7_value_display #(.BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst(rst), .value(value), .hex_mode(hex_mode),
        .HEX0(z_hex[0]), .HEX1(z_hex[1]), .HEX2(z_hex[2]), .HEX3(z_hex[3]),
        .HEX4(z_hex[4]), .HEX5(z_hex[5]), .HEX6(z_hex[6]), .HEX7(z_hex[7]),
        .busy(z_busy), .overflow(z_ovf)
    );

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // What display idx must show for value v.
    function automatic logic [6:0] exp_seg(input logic [31:0] v, input bit hx, input bit blz, input int idx);
        longint p;
        int     d;
        bit     lead;
        if (!hx && (v > 32'd99999999)) return 7'b0111111;
        if (hx) begin
            d    = int'((v >> (4 * idx)) & 32'hF);
            lead = (idx > 0) && ((v >> (4 * idx)) == 32'd0);
        end else begin
            p = 1;
            for (int k = 0; k < idx; k++) p = p * 10;
            d    = int'((longint'(v) / p) % 10);
            lead = (idx > 0) && (longint'(v) < p);
        end
        if (blz && lead) return 7'b1111111;
        return seg_tab[d];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_left     = 0;     // edges remaining until the display is loaded
    bit          m_dirty    = 1'b1;
    logic [31:0] m_last_val = 32'd0;
    bit          m_last_hex = 1'b0;
    logic [31:0] m_cap_val  = 32'd0;
    bit          m_cap_hex  = 1'b0;
    bit          m_busy     = 1'b0;
    bit          m_ovf      = 1'b0;
    logic [6:0]  m_hex1 [8] = '{default: 7'b1111111};
    logic [6:0]  m_hex0 [8] = '{default: 7'b1111111};

    // Model: capture takes one edge, then 32 shift edges (decimal) before the load edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left  <= 0;
            m_dirty <= 1'b1;
            m_busy  <= 1'b0;
            m_ovf   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                m_hex1[i] <= 7'b1111111;
                m_hex0[i] <= 7'b1111111;
            end
        end else if (m_left == 0) begin
            if (m_dirty || (value != m_last_val) || (hex_mode != m_last_hex)) begin
                m_cap_val  <= value;
                m_cap_hex  <= hex_mode;
                m_last_val <= value;
                m_last_hex <= hex_mode;
                m_dirty    <= 1'b0;
                m_busy     <= 1'b1;
                m_left     <= hex_mode ? 1 : 33;
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_ovf  <= !m_cap_hex && (m_cap_val > 32'd99999999);
                for (int i = 0; i < 8; i++) begin
                    m_hex1[i] <= exp_seg(m_cap_val, m_cap_hex, 1'b1, i);
                    m_hex0[i] <= exp_seg(m_cap_val, m_cap_hex, 1'b0, i);
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("blz1_HEX%0d", i), a_hex[i], m_hex1[i]);
                check($sformatf("blz0_HEX%0d", i), z_hex[i], m_hex0[i]);
            end
            check("blz1_busy", a_busy, m_busy);
            check("blz0_busy", z_busy, m_busy);
            check("blz1_overflow", a_ovf, m_ovf);
            check("blz0_overflow", z_ovf, m_ovf);
        end
    end

    task automatic wait_idle(input int max_cyc);
        bit done;
        done = 1'b0;
        for (int c = 0; c < max_cyc && !done; c++) begin
            @(negedge clk);
            if (m_left == 0 && !m_dirty && value == m_last_val && hex_mode == m_last_hex && !a_busy)
                done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_idle: no idle within %0d cycles", max_cyc);
        end
    endtask

    task automatic count_busy(output int cnt);
        bit seen;
        cnt  = 0;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (a_busy) begin
                cnt++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
    endtask

    task automatic set_in(input logic [31:0] v, input logic h);
        @(negedge clk);
        value    = v;
        hex_mode = h;
    endtask

    int bc;

    initial begin
        // Reset state with value 0.
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) check("reset_blank", a_hex[i], 7'b1111111);
        check("reset_busy", a_busy, 1'b0);
        check("reset_ovf", a_ovf, 1'b0);

        // Release: zero appears on HEX0 by edge 34.
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (34) @(negedge clk);
        check("zero_HEX0", a_hex[0], 7'b1000000);
        check("zero_HEX1", a_hex[1], 7'b1111111);
        check("zero_HEX7", a_hex[7], 7'b1111111);
        check("zero_noblank_HEX7", z_hex[7], 7'b1000000);
        check("zero_noblank_HEX3", z_hex[3], 7'b1000000);

        // value = 2 decimal: busy for 33 cycles.
        set_in(32'd2, 1'b0);
        count_busy(bc);
        check("dec2_busy_cycles", bc, 33);
        check("dec2_HEX0", a_hex[0], 7'b0100100);
        check("dec2_HEX1", a_hex[1], 7'b1111111);

        // 12345678 decimal.
        set_in(32'd12345678, 1'b0);
        wait_idle(200);
        check("dec8_HEX7", a_hex[7], 7'b1111001);
        check("dec8_HEX3", a_hex[3], 7'b0010010);
        check("dec8_HEX0", a_hex[0], 7'b0000000);

        // 100000000 decimal: overflow dashes.
        set_in(32'd100000000, 1'b0);
        wait_idle(200);
        check("ovf_flag", a_ovf, 1'b1);
        check("ovf_HEX0", a_hex[0], 7'b0111111);
        check("ovf_HEX7", z_hex[7], 7'b0111111);

        // Hex DEADBEEF: one busy cycle.
        set_in(32'hDEADBEEF, 1'b1);
        count_busy(bc);
        check("hex_busy_cycles", bc, 1);
        check("hex_HEX7", a_hex[7], 7'b0100001);
        check("hex_HEX6", a_hex[6], 7'b0000110);
        check("hex_HEX5", a_hex[5], 7'b0001000);
        check("hex_HEX0", a_hex[0], 7'b0001110);
        check("hex_ovf", a_ovf, 1'b0);

        // 5 -> 9 during the conversion.
        set_in(32'd5, 1'b0);
        @(negedge clk);
        repeat (10) @(negedge clk);
        value = 32'd9;
        for (int c = 0; c < 60 && a_busy; c++) @(negedge clk);
        check("midflight_first", a_hex[0], 7'b0010010);
        wait_idle(100);
        check("midflight_second", a_hex[0], 7'b0010000);

        // Reset during SHIFT.
        set_in(32'd987, 1'b0);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midreset_HEX0", a_hex[0], 7'b1111111);
        check("midreset_busy", a_busy, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        wait_idle(200);
        check("post_reset_HEX0", a_hex[0], 7'b1111000);
        check("post_reset_HEX2", a_hex[2], 7'b0010000);
        check("post_reset_HEX3", a_hex[3], 7'b1111111);

        // Randomised values, modes and mid-conversion changes.
        for (int it = 0; it < 40; it++) begin
            logic [31:0] v;
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: v = 32'($urandom_range(0, 99));
                2: v = 32'd99999990 + 32'($urandom_range(0, 20));
                default: v = 32'($urandom_range(0, 99999999));
            endcase
            set_in(v, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 40)) @(negedge clk);
                value = $urandom;
            end
            wait_idle(200);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
